mysystem_avm_pio_master: RTL and testbench
==========================================

Name: mysystem_avm_pio_master

Overview:
Avalon-MM master that issues single read and write transactions to memory-mapped peripherals, such as the PIO slaves in mysystem. It accepts one command at a time on a valid/ready port. It drives chipselect, write_n, read and address onto the bus, honours waitrequest, and captures read data after a fixed read latency. Each completed transaction produces a one-cycle response pulse. Typical use is a hardware sequencer that pokes control bits (e.g. a VGA start flag) without the Nios processor.

Parameters:
ADDR_W, 2, width of the Avalon word address.
DATA_W, 32, width of write and read data.
READ_LATENCY, 1, cycles from read accept to valid avm_readdata; legal range 1..7.
TIMEOUT_CYCLES, 255, waitrequest cycles tolerated before abort (used only with the optional feature).

Ports:
clk  in  1  system clock; all logic on the rising edge.
reset_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
cmd_valid  in  1  command present.
cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid & cmd_ready.
cmd_write  in  1  1 = write, 0 = read.
cmd_address  in  ADDR_W  target word address.
cmd_writedata  in  DATA_W  write data.
rsp_valid  out  1  one-cycle completion pulse.
rsp_readdata  out  DATA_W  captured read data; 0 for writes.
rsp_error  out  1  transaction aborted by timeout.
avm_address  out  ADDR_W  bus address.
avm_chipselect  out  1  bus select.
avm_write_n  out  1  active-low write strobe.
avm_read  out  1  active-high read strobe.
avm_writedata  out  DATA_W  bus write data.
avm_readdata  in  DATA_W  slave read data.
avm_waitrequest  in  1  slave stall.

Behaviour:
- Reset (reset_n == 0 at a clk edge):
  - state = IDLE; avm_chipselect = 0, avm_write_n = 1, avm_read = 0.
  - avm_address = 0, avm_writedata = 0.
  - rsp_valid = 0, rsp_readdata = 0, rsp_error = 0; latency and timeout counters = 0.
  - Reset mid-transaction drops the transaction: no response is issued, and bus strobes are deasserted at that same edge.
- All outputs are registered. cmd_ready is decoded from state == IDLE.
- States: IDLE, WR, RD, RD_WAIT, RESP.
- IDLE:
  - On accept, latch cmd_address/cmd_writedata into avm_address/avm_writedata and set avm_chipselect = 1.
  - cmd_write = 1: avm_write_n = 0, go to WR.
  - cmd_write = 0: avm_read = 1, go to RD.
  - cmd_valid with cmd_ready low is ignored; no queueing.
- WR:
  - Hold all bus signals while avm_waitrequest = 1.
  - At the first edge with avm_waitrequest = 0 (accept edge), deassert chipselect and write_n, go to RESP with rsp_readdata = 0.
  - A write with no waitrequest occupies exactly one bus cycle.
- RD:
  - Same hold rule as WR.
  - At the accept edge, deassert chipselect and read, load latency counter = READ_LATENCY, go to RD_WAIT.
- RD_WAIT:
  - Counter decrements each edge.
  - At the edge where the counter == 1, capture avm_readdata into rsp_readdata and go to RESP.
  - With READ_LATENCY = 1, data is sampled in the cycle after the accept cycle.
- RESP:
  - rsp_valid = 1 for exactly one cycle, then return to IDLE.
  - rsp_readdata and rsp_error hold until the next response.
- Throughput:
  - Write: accept → rsp_valid = 2 cycles minimum.
  - Read: READ_LATENCY + 2 cycles minimum.
  - Next command is accepted in the cycle after rsp_valid.
- Only one transaction is outstanding. avm_write_n = 0 and avm_read = 1 are never asserted together.
- avm_address and avm_writedata keep their last values while idle. Slaves qualify them with chipselect.

Optional Feature:
- Macro: MYSYSTEM_AVM_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter increments in WR/RD while avm_waitrequest = 1 and clears on state entry.
  - When the count reaches TIMEOUT_CYCLES, deassert all strobes and go to RESP with rsp_error = 1 and rsp_readdata = 0.
- Undefined:
  - No counter; the master waits indefinitely and rsp_error is tied to 0.

Test Plan:
1. Write, no stall: cmd write addr=0 data=0x00000001, waitrequest=0 → one cycle with chipselect=1, write_n=0, address=0, writedata=0x1; rsp_valid 2 cycles after accept; rsp_readdata=0, rsp_error=0.
2. Read against PIO model (latency 1, in_port=1): cmd read addr=0 → read=1 for one cycle; rsp_valid 3 cycles after accept; rsp_readdata=0x00000001.
3. Waitrequest stall: write addr=2 data=0xDEADBEEF with waitrequest high for 4 cycles → bus signals stable all 5 cycles; rsp_valid 1 cycle after the unstalled edge; cmd_ready low throughout.
4. Back-to-back: cmd_valid held high with write then read queued by the driver → second accept occurs in the cycle after the first rsp_valid; strobes never overlap.
5. Reset mid-read: reset_n=0 in RD_WAIT → strobes 0 and rsp_valid stays 0; after release cmd_ready=1 and a new read returns correct data.
6. With MYSYSTEM_AVM_TIMEOUT_EN and TIMEOUT_CYCLES=8, waitrequest stuck high → strobes drop after 8 stall cycles; rsp_valid=1 with rsp_error=1 and rsp_readdata=0. Without the macro, still waiting after 1000 cycles.

Source files
------------

// File: rtl/mysystem_avm_pio_master_if.sv
// Command, response and Avalon-MM bus signals of mysystem_avm_pio_master.
//
// Handshake: a command moves from the requester to the master on a rising clk
// edge where cmd_valid & cmd_ready are both high. cmd_ready is high only while
// the master is idle. cmd_valid may stay high while cmd_ready is low; nothing
// is queued and the command fields are sampled only on the accepting edge.
// rsp_valid is a one-cycle pulse with no back-pressure. rsp_readdata and
// rsp_error hold their values until the next pulse.
interface mysystem_avm_pio_master_if #(
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_address;
  logic [DATA_W-1:0] cmd_writedata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_readdata;
  logic              rsp_error;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_chipselect;
  logic              avm_write_n;
  logic              avm_read;
  logic [DATA_W-1:0] avm_writedata;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_waitrequest;

  modport master (
    input  cmd_valid, cmd_write, cmd_address, cmd_writedata,
    input  avm_readdata, avm_waitrequest,
    output cmd_ready, rsp_valid, rsp_readdata, rsp_error,
    output avm_address, avm_chipselect, avm_write_n, avm_read, avm_writedata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_address, cmd_writedata,
    output avm_readdata, avm_waitrequest,
    input  cmd_ready, rsp_valid, rsp_readdata, rsp_error,
    input  avm_address, avm_chipselect, avm_write_n, avm_read, avm_writedata
  );
endinterface

// File: rtl/mysystem_avm_pio_master.sv
// Avalon-MM single-transaction master for the mysystem PIO slaves.
// Takes one read or write command at a time, drives the bus until the slave
// drops waitrequest, collects read data after READ_LATENCY cycles and reports
// completion with a one-cycle rsp_valid pulse. Every output is registered.
// Optional build macro MYSYSTEM_AVM_TIMEOUT_EN adds a waitrequest timeout that
// aborts the transaction with rsp_error after TIMEOUT_CYCLES stalled cycles.
// dbg_state exposes the FSM state (IDLE=0, WR=1, RD=2, RD_WAIT=3, RESP=4).
module mysystem_avm_pio_master #(
  parameter int unsigned ADDR_W         = 2,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     reset_n,
  mysystem_avm_pio_master_if.master bus,
  output logic [2:0]               dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD      = 3'd2,
    RD_WAIT = 3'd3,
    RESP    = 3'd4
  } state_t;

  // READ_LATENCY must lie in 1..7 (3-bit counter) and TIMEOUT_CYCLES in 1..65535
  // (16-bit counter); other values are an illegal configuration.
  if (READ_LATENCY < 1 || READ_LATENCY > 7 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535)
  begin : g_illegal_params
  end

  state_t            state_q, state_d;
  logic              cs_q, cs_d;
  logic              write_n_q, write_n_d;
  logic              read_q, read_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [2:0]        lat_q, lat_d;
  logic              bus_phase;
  logic              timeout_hit;

  assign bus_phase = (state_q == WR) || (state_q == RD);

`ifdef MYSYSTEM_AVM_TIMEOUT_EN
  logic [15:0] to_q;

  // Count stalled bus cycles; the count is zero whenever a bus phase begins.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      to_q <= '0;
    end else if (bus_phase && bus.avm_waitrequest) begin
      to_q <= to_q + 16'd1;
    end else begin
      to_q <= '0;
    end
  end

  assign timeout_hit = bus_phase && bus.avm_waitrequest &&
                       (to_q == 16'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // State and all output registers; reset drops any transaction in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cs_q        <= 1'b0;
      write_n_q   <= 1'b1;
      read_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      lat_q       <= '0;
    end else begin
      state_q     <= state_d;
      cs_q        <= cs_d;
      write_n_q   <= write_n_d;
      read_q      <= read_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      lat_q       <= lat_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.cmd_valid) state_d = bus.cmd_write ? WR : RD;
      WR:      if (timeout_hit || !bus.avm_waitrequest) state_d = RESP;
      RD: begin
        if (timeout_hit)                state_d = RESP;
        else if (!bus.avm_waitrequest)  state_d = RD_WAIT;
      end
      RD_WAIT: if (lat_q == 3'd1) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the state transition.
  always_comb begin
    cs_d        = cs_q;
    write_n_d   = write_n_q;
    read_d      = read_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    lat_d       = lat_q;
    rsp_valid_d = (state_d == RESP);

    // Accept: latch the command and raise exactly one strobe.
    if (state_q == IDLE && bus.cmd_valid) begin
      addr_d    = bus.cmd_address;
      wdata_d   = bus.cmd_writedata;
      cs_d      = 1'b1;
      write_n_d = !bus.cmd_write;
      read_d    = !bus.cmd_write;
    end

    // Leaving the bus phase (slave accepted or timed out) drops the strobes.
    if (bus_phase && state_d != state_q) begin
      cs_d      = 1'b0;
      write_n_d = 1'b1;
      read_d    = 1'b0;
    end

    if (state_q == RD && state_d == RD_WAIT) begin
      lat_d = 3'(READ_LATENCY);
    end else if (state_q == RD_WAIT) begin
      lat_d = lat_q - 3'd1;
    end

    // Entering RESP: only a completed read carries data; writes and aborts give 0.
    if (state_d == RESP && state_q != RESP) begin
      rdata_d = (state_q == RD_WAIT) ? bus.avm_readdata : '0;
      err_d   = timeout_hit;
    end
  end

  assign bus.cmd_ready      = (state_q == IDLE);
  assign bus.avm_chipselect = cs_q;
  assign bus.avm_write_n    = write_n_q;
  assign bus.avm_read       = read_q;
  assign bus.avm_address    = addr_q;
  assign bus.avm_writedata  = wdata_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_readdata   = rdata_q;
  assign bus.rsp_error      = err_q;
  assign dbg_state          = state_q;

endmodule

// File: tb/tb_mysystem_avm_pio_master.sv
// Testbench for mysystem_avm_pio_master: directed transactions against a
// latency-1 PIO-style slave. A transaction-level model turns each accepted
// command into its expected per-cycle output trace; one compare process
// checks every cycle against it (idle expectations when nothing is queued).
// Builds with or without MYSYSTEM_AVM_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_mysystem_avm_pio_master;
  localparam int unsigned AW      = 2;
  localparam int unsigned DW      = 32;
  localparam int unsigned RL      = 1;
  localparam int unsigned TO      = 8;
  localparam int unsigned STUCK_N = 1000;
`ifdef MYSYSTEM_AVM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct packed {
    logic          rdy;
    logic          cs;
    logic          wn;
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          rv;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] dbg_state;

  mysystem_avm_pio_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mysystem_avm_pio_master #(
    .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- slave: PIO-like register file, read latency 1 ----------------
  logic [DW-1:0] slv_mem [4] = '{32'h0000_0001, 32'h0000_0011, 32'h0000_0022, 32'h0000_0033};
  logic          slv_rv = 1'b0;
  logic [DW-1:0] slv_rd = '0;

  always @(posedge clk) begin
    slv_rv <= bus.avm_chipselect && bus.avm_read && !bus.avm_waitrequest;
    slv_rd <= slv_mem[bus.avm_address];
    if (bus.avm_chipselect && !bus.avm_write_n && !bus.avm_waitrequest)
      slv_mem[bus.avm_address] <= bus.avm_writedata;
  end
  // Data is valid only in the single cycle after the read is accepted.
  assign bus.avm_readdata = slv_rv ? slv_rd : 32'hBAD0_BAD0;

  // ---------------- model and scoreboard ----------------
  logic [DW-1:0]    m_mem [4] = '{32'h0000_0001, 32'h0000_0011, 32'h0000_0022, 32'h0000_0033};
  logic [AW-1:0]    m_addr  = '0;
  logic [DW-1:0]    m_wdata = '0;
  logic [DW-1:0]    m_rdata = '0;
  logic             m_err   = 1'b0;
  logic [EXP_W-1:0] exp_q[$];
  string            tag_q[$];
  bit               chk_en = 1'b0;
  int               n_vec  = 0;
  int               n_err  = 0;

  function automatic exp_t mk(input bit rdy, input bit cs, input bit wn, input bit rd, input bit rv);
    exp_t e;
    e.rdy = rdy; e.cs = cs; e.wn = wn; e.rd = rd;
    e.addr = m_addr; e.wdata = m_wdata;
    e.rv = rv; e.rdata = m_rdata; e.err = m_err;
    return e;
  endfunction

  function automatic void push(input string tag, input bit cs, input bit wn, input bit rd, input bit rv);
    exp_q.push_back(mk(1'b0, cs, wn, rd, rv));
    tag_q.push_back(tag);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  // Compare every cycle, sampled on the falling edge.
  exp_t             cur;
  string            cur_tag;
  logic [EXP_W-1:0] act;
  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_q.size() != 0) begin
        cur     = exp_q.pop_front();
        cur_tag = tag_q.pop_front();
      end else begin
        cur     = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cur_tag = "idle";
      end
      act = {bus.cmd_ready, bus.avm_chipselect, bus.avm_write_n, bus.avm_read,
             bus.avm_address, bus.avm_writedata, bus.rsp_valid, bus.rsp_readdata,
             bus.rsp_error};
      n_vec++;
      if (act !== cur) begin
        n_err++;
        $display("FAIL %s @%0t: got {rdy,cs,wn,rd,addr,wdata,rv,rdata,err}=%h, want %h",
                 cur_tag, $time, act, cur);
      end
    end
  end

  // Accept-to-response latency and response-to-next-accept gap, in clock edges.
  int cyc = 0, acc_cyc = 0, rsp_cyc = -100, lat = -1, gap = -1;
  always @(posedge clk) begin
    if (reset_n && bus.cmd_valid && bus.cmd_ready) begin
      gap     = cyc - rsp_cyc;
      acc_cyc = cyc;
    end
    if (bus.rsp_valid) begin
      rsp_cyc = cyc;
      lat     = cyc - acc_cyc;
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  // Called on a falling edge. Presents a command, waits for acceptance, queues
  // the expected trace and plays the slave's waitrequest. Returns on the
  // falling edge of the last expected cycle with cmd_valid still high (junk
  // fields), so a caller can chain the next command immediately.
  task automatic do_txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int stall, input bit stuck);
    bit ok;
    int nb;
    int n;
    bus.cmd_write     = wr;
    bus.cmd_address   = a;
    bus.cmd_writedata = d;
    bus.cmd_valid     = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus.cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: cmd_ready got 0 for 20 cycles, want 1");
      bus.cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    m_addr  = a;
    m_wdata = d;
    nb = stuck ? (TO_EN ? int'(TO) : int'(STUCK_N)) : stall + 1;
    n  = 0;
    for (int i = 0; i < nb; i++) begin
      push(wr ? "wr_bus" : "rd_bus", 1'b1, !wr, !wr, 1'b0);
      n++;
    end
    if (!stuck || TO_EN) begin
      if (!wr && !stuck) begin
        for (int i = 0; i < int'(RL); i++) begin
          push("rd_wait", 1'b0, 1'b1, 1'b0, 1'b0);
          n++;
        end
      end
      if (stuck) begin
        m_rdata = '0;
        m_err   = 1'b1;
      end else if (wr) begin
        m_rdata  = '0;
        m_err    = 1'b0;
        m_mem[a] = d;
      end else begin
        m_rdata = m_mem[a];
        m_err   = 1'b0;
      end
      push("resp", 1'b0, 1'b1, 1'b0, 1'b1);
      n++;
    end
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus.cmd_write     = !wr;
        bus.cmd_address   = ~a;
        bus.cmd_writedata = ~d;
      end
      bus.avm_waitrequest = stuck ? 1'b1 : (i <= stall);
    end
    if (!stuck || TO_EN) bus.avm_waitrequest = 1'b0;
  endtask

  // Called on a falling edge with checking disabled: reset for one edge,
  // check the reset outputs, and restart the model from reset values.
  task automatic reset_now(input string name);
    reset_n = 1'b0;
    @(negedge clk);
    chk({name, "_strobes"}, {28'd0, bus.avm_chipselect, bus.avm_read, !bus.avm_write_n, bus.rsp_valid}, 32'd0);
    chk({name, "_ready"}, {31'd0, bus.cmd_ready}, 32'd1);
    chk({name, "_rdata"}, bus.rsp_readdata, 32'd0);
    reset_n = 1'b1;
    bus.avm_waitrequest = 1'b0;
    @(negedge clk);
    chk({name, "_norsp"}, {31'd0, bus.rsp_valid}, 32'd0);
    exp_q.delete();
    tag_q.delete();
    m_addr = '0; m_wdata = '0; m_rdata = '0; m_err = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n             = 1'b0;
    bus.cmd_valid       = 1'b0;
    bus.cmd_write       = 1'b0;
    bus.cmd_address     = '0;
    bus.cmd_writedata   = '0;
    bus.avm_waitrequest = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("rst_strobes", {29'd0, bus.avm_chipselect, !bus.avm_write_n, bus.avm_read}, 32'd0);
    chk("rst_addr", {30'd0, bus.avm_address}, 32'd0);
    chk("rst_wdata", bus.avm_writedata, 32'd0);
    chk("rst_rsp", {30'd0, bus.rsp_valid, bus.rsp_error}, 32'd0);
    chk("rst_rdata", bus.rsp_readdata, 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);

    // 1: write without stall
    do_txn(1'b1, 2'd0, 32'h0000_0001, 0, 1'b0);
    chk("t1_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("t1_rdata", bus.rsp_readdata, 32'd0);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("t1_lat", lat, 32'd2);

    // 2: read from the PIO input (value 1)
    do_txn(1'b0, 2'd0, 32'h0, 0, 1'b0);
    chk("t2_rdata", bus.rsp_readdata, 32'h0000_0001);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("t2_lat", lat, 32'd3);

    // 3: write held off by four waitrequest cycles
    do_txn(1'b1, 2'd2, 32'hDEAD_BEEF, 4, 1'b0);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("t3_lat", lat, 32'd6);

    // 4: back-to-back write, read, read with cmd_valid kept high
    do_txn(1'b1, 2'd3, 32'hA5A5_0003, 0, 1'b0);
    do_txn(1'b0, 2'd3, 32'h0, 0, 1'b0);
    chk("t4_rdata3", bus.rsp_readdata, 32'hA5A5_0003);
    chk("t4_gap", gap, 32'd1);
    do_txn(1'b0, 2'd2, 32'h0, 0, 1'b0);
    chk("t4_rdata2", bus.rsp_readdata, 32'hDEAD_BEEF);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("t4_lat", lat, 32'd3);

    // 5: reset while waiting for read data
    @(posedge clk);
    chk_en = 1'b0;
    @(negedge clk);
    bus.cmd_write   = 1'b0;
    bus.cmd_address = 2'd1;
    bus.cmd_valid   = 1'b1;
    chk("t5_ready", {31'd0, bus.cmd_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("t5_rd_strobe", {30'd0, bus.avm_chipselect, bus.avm_read}, 32'd3);
    @(negedge clk);
    chk("t5_rd_wait", {30'd0, bus.avm_chipselect, bus.avm_read}, 32'd0);
    reset_now("t5");
    @(negedge clk);
    do_txn(1'b0, 2'd1, 32'h0, 0, 1'b0);
    chk("t5_rdata", bus.rsp_readdata, 32'h0000_0011);
    bus.cmd_valid = 1'b0;

    // 6: waitrequest stuck high
    @(negedge clk);
    do_txn(1'b0, 2'd1, 32'h0, 0, 1'b1);
`ifdef MYSYSTEM_AVM_TIMEOUT_EN
    chk("t6_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("t6_error", {31'd0, bus.rsp_error}, 32'd1);
    chk("t6_rdata", bus.rsp_readdata, 32'd0);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("t6_lat", lat, TO + 1);
`else
    bus.cmd_valid = 1'b0;
    chk("t6_still_waiting", {30'd0, bus.avm_chipselect, bus.avm_read}, 32'd3);
    chk("t6_no_error", {31'd0, bus.rsp_error}, 32'd0);
    @(posedge clk);
    chk_en = 1'b0;
    @(negedge clk);
    reset_now("t6");
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finish before 200000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
